// File: rtl/spi_pattern_gen.sv
// spi_pattern_gen: burst test-pattern source for the SPI FIFO write port.
// Emits bursts of counter / LFSR / walking-one / alternating words,
// rotating round-robin over enabled channels with a programmable gap.
module spi_pattern_gen #(
  parameter int          DATA_W    = 32,
  parameter int          N_CH      = 4,
  parameter int          CH_W      = $clog2(N_CH),
  parameter int          TAG_EN    = 1,
  parameter int          DLY_W     = 32,
  parameter logic [31:0] LFSR_TAPS = 32'h8020_0003
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              enable,
  input  logic [1:0]        mode,
  input  logic [4:0]        delay_exp,
  input  logic [7:0]        burst_len,
  input  logic [N_CH-1:0]   ch_mask,
  input  logic              block,
  input  logic              full,
  output logic              we,
  output logic [DATA_W-1:0] din,
  output logic [CH_W-1:0]   ch_id,
  output logic              tick,
  output logic              busy,
  output logic [31:0]       word_cnt
);

  localparam int PAT_W = (TAG_EN != 0) ? DATA_W - CH_W : DATA_W;
  localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [PAT_W-1:0] TAPS = PAT_W'(LFSR_TAPS);

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_DELAY, S_SEND, S_GAP} state_e;

  state_e            state_q;
  logic [1:0]        mode_q;
  logic [DLY_W-1:0]  delay_q;
  logic [DLY_W-1:0]  delay_cnt_q;
  logic [7:0]        remaining_q;
  logic [CH_W-1:0]   ch_id_q;
  logic [CH_W-1:0]   rot_q;
  logic [PAT_W-1:0]  cnt_q;
  logic [PAT_W-1:0]  lfsr_q;
  logic [IDX_W-1:0]  walk_q;
  logic              alt_q;
  logic [31:0]       word_cnt_q;

  logic [PAT_W-1:0]  cnt_d;
  logic [PAT_W-1:0]  lfsr_d;
  logic [IDX_W-1:0]  walk_d;
  logic [CH_W-1:0]   rot_d;
  logic [CH_W-1:0]   next_ch;
  logic [CH_W:0]     cand;
  logic [DLY_W-1:0]  delay_val;
  logic [PAT_W-1:0]  alt_pat;
  logic [PAT_W-1:0]  pat;

  // Inter-burst delay length, exponent clamped to the counter width.
  always_comb begin
    if (32'(delay_exp) >= 32'(DLY_W)) delay_val = DLY_W'(1) << (DLY_W - 1);
    else                              delay_val = DLY_W'(1) << delay_exp;
  end

  // First enabled channel at or after the rotation pointer (lowest offset wins).
  always_comb begin
    next_ch = rot_q;
    cand    = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      cand = {1'b0, rot_q} + (CH_W+1)'(i);
      if (cand >= (CH_W+1)'(N_CH)) cand = cand - (CH_W+1)'(N_CH);
      if (ch_mask[cand[CH_W-1:0]]) next_ch = cand[CH_W-1:0];
    end
  end

  // Next values of the pattern generators and the rotation pointer.
  always_comb begin
    cnt_d  = cnt_q + PAT_W'(1);
    lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
    walk_d = (walk_q == IDX_W'(PAT_W - 1)) ? '0 : walk_q + IDX_W'(1);
    rot_d  = (ch_id_q == CH_W'(N_CH - 1)) ? '0 : ch_id_q + CH_W'(1);
  end

  // Current pattern word; alternating phase 0 gives 0x55.., phase 1 gives 0xAA..
  always_comb begin
    for (int i = 0; i < PAT_W; i++) alt_pat[i] = (i % 2 == 0) ? ~alt_q : alt_q;
    case (mode_q)
      2'd0:    pat = cnt_q;
      2'd1:    pat = lfsr_q;
      2'd2:    pat = PAT_W'(1) << walk_q;
      default: pat = alt_pat;
    endcase
  end

  generate
    if (TAG_EN != 0) begin : g_tag
      assign din = {ch_id_q, pat};
    end else begin : g_notag
      assign din = pat;
    end
  endgenerate

  assign we       = (state_q == S_SEND) && !full;
  assign tick     = (state_q == S_ARM) || (state_q == S_GAP);
  assign busy     = (state_q != S_IDLE);
  assign ch_id    = ch_id_q;
  assign word_cnt = word_cnt_q;

  // Burst sequencer; only the selected pattern advances on an accepted word,
  // and pattern state is shared by all channels across bursts.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= S_IDLE;
      mode_q      <= '0;
      delay_q     <= '0;
      delay_cnt_q <= '0;
      remaining_q <= '0;
      ch_id_q     <= '0;
      rot_q       <= '0;
      cnt_q       <= '0;
      lfsr_q      <= PAT_W'(1);
      walk_q      <= '0;
      alt_q       <= 1'b0;
      word_cnt_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (enable && (|ch_mask)) state_q <= S_ARM;
        end
        S_ARM: begin
          mode_q      <= mode;
          delay_q     <= delay_val;
          remaining_q <= (burst_len == 8'd0) ? 8'd1 : burst_len;
          delay_cnt_q <= '0;
          ch_id_q     <= next_ch;
          state_q     <= S_DELAY;
        end
        S_DELAY: begin
          if ((delay_cnt_q >= delay_q) && !block) state_q <= S_SEND;
          else if (delay_cnt_q != '1)             delay_cnt_q <= delay_cnt_q + DLY_W'(1);
        end
        S_SEND: begin
          if (!full) begin
            case (mode_q)
              2'd0:    cnt_q  <= cnt_d;
              2'd1:    lfsr_q <= lfsr_d;
              2'd2:    walk_q <= walk_d;
              default: alt_q  <= ~alt_q;
            endcase
            word_cnt_q  <= word_cnt_q + 32'd1;
            remaining_q <= remaining_q - 8'd1;
            if (remaining_q == 8'd1) state_q <= S_GAP;
          end
        end
        S_GAP: begin
          rot_q   <= rot_d;
          state_q <= (enable && (|ch_mask)) ? S_ARM : S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
